// File: rtl/spdif_i2s_out.sv
// -----------------------------------------------------------------------------
// spdif_i2s_out
//
// Purpose:
//   Downstream stage of the S/PDIF receiver. Each level change of the wr_en
//   toggle strobe delivers one complete left/right sample pair. Pairs are
//   buffered in a small FIFO and serialised as a standard I2S stream (BCLK,
//   LRCK, SDATA, MSB first, one BCLK of delay after each LRCK change) for an
//   external DAC. BCLK is derived from wb_clk_i by an integer divider and runs
//   continuously after reset.
//
// Parameters:
//   DATA_WIDTH  sample width per channel (8..24); the rest of the 32-bit slot
//               is sent as zeros.
//   FIFO_AW     FIFO address width; depth is 2**FIFO_AW stereo pairs (>= 1).
//   BCLK_DIV    wb_clk_i cycles per BCLK half-period (>= 1).
//
// Ports:
//   wb_clk_i     in   system clock, sole clock of the block
//   wb_rst_i     in   synchronous active-high reset
//   wr_en        in   toggle strobe, each level change = one new L/R pair
//   wr_data_lch  in   left sample, stable when wr_en toggles
//   wr_data_rch  in   right sample, stable when wr_en toggles
//   lock         in   receiver lock (only used with the optional feature)
//   stat_clr     in   one-cycle pulse clearing the sticky flags
//   i2s_bclk     out  bit clock
//   i2s_lrck     out  word select (0 = left, 1 = right)
//   i2s_sdata    out  serial data, MSB first
//   fifo_level   out  number of stored pairs
//   overrun      out  sticky: a pair was dropped on a full FIFO
//   underrun     out  sticky: FIFO empty at a frame load while running
//
// Optional feature (macro SPDIF_I2S_LOCK_MUTE_EN):
//   When defined, lock = 0 flushes the FIFO, stops the running state, ignores
//   pushes and forces zero frames while BCLK/LRCK keep running. Without the
//   macro, lock is ignored.
// -----------------------------------------------------------------------------
module spdif_i2s_out #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_AW    = 2,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data_lch,
  input  logic [DATA_WIDTH-1:0] wr_data_rch,
  input  logic                  lock,
  input  logic                  stat_clr,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PAD_W = 32 - DATA_WIDTH;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   HALF_LVL = (FIFO_AW + 1)'(DEPTH / 2);

  // Pair storage: {left, right}. No reset needed, pointers define validity.
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];

  logic                 wr_en_q;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 bclk_q, bclk_d;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic                 lrck_q, lrck_d;
  logic                 sdata_q, sdata_d;
  logic [63:0]          frame_q, frame_d;
  logic                 running_q, running_d;
  logic                 overrun_q, overrun_d;
  logic                 underrun_q, underrun_d;

  logic                 mute;
  logic                 push;
  logic                 tc;
  logic                 shift_ev;
  logic                 frame_ev;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 wr_ok;
  logic                 ovf_set;
  logic                 unf_set;
  logic [5:0]           bit_cnt_inc;
  logic [2*DATA_WIDTH-1:0] head;
  logic [63:0]          head_frame;

`ifdef SPDIF_I2S_LOCK_MUTE_EN
  assign mute = ~lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign mute        = 1'b0;
`endif

  assign push       = wr_en ^ wr_en_q;
  assign tc         = (div_cnt_q == DIV_LAST);
  // BCLK falls when it toggles from high: that is the shift event.
  assign shift_ev   = tc & bclk_q;
  // The shift event that wraps bit_cnt to 0 is the frame boundary.
  assign frame_ev   = shift_ev & (bit_cnt_q == 6'd63);
  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);
  assign pop        = frame_ev & running_q & ~fifo_empty & ~mute;
  // A pop in the same cycle frees the slot the full FIFO needs.
  assign wr_ok      = push & ~mute & (~fifo_full | pop);
  assign ovf_set    = push & ~mute & fifo_full & ~pop;
  assign bit_cnt_inc = bit_cnt_q + 6'd1;

  // Read-first: a simultaneous write to the head slot lands after this read.
  assign head       = mem[rd_ptr_q];
  assign head_frame = {head[2*DATA_WIDTH-1:DATA_WIDTH], {PAD_W{1'b0}},
                       head[DATA_WIDTH-1:0],            {PAD_W{1'b0}}};

  always_comb begin
    div_cnt_d  = tc ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d     = bclk_q ^ tc;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    frame_d    = frame_q;
    running_d  = running_q;
    unf_set    = 1'b0;

    // The 64-bit frame register shifts out MSB first; the bit presented at
    // the frame boundary is the last right-slot bit of the previous frame,
    // which gives the one-BCLK delay after LRCK changes.
    if (shift_ev) begin
      bit_cnt_d = bit_cnt_inc;
      lrck_d    = bit_cnt_inc[5];
      sdata_d   = frame_q[63];
      frame_d   = {frame_q[62:0], 1'b0};
    end

    if (frame_ev) begin
      frame_d = '0;
      if (mute) begin
        running_d = 1'b0;
      end else if (running_q) begin
        if (!fifo_empty) begin
          frame_d = head_frame;
        end else begin
          unf_set   = 1'b1;
          running_d = 1'b0;
        end
      end else if (level_q >= HALF_LVL) begin
        // Primed to half full: real samples start at the next boundary.
        running_d = 1'b1;
      end
    end

    if (mute) begin
      running_d = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + FIFO_AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    case ({wr_ok, pop})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase

    if (mute) begin
      level_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end

    // A set condition in the same cycle wins over the clear.
    overrun_d  = ovf_set | (overrun_q & ~stat_clr);
    underrun_d = unf_set | (underrun_q & ~stat_clr);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_en_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      frame_q    <= '0;
      running_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_en_q    <= wr_en;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      frame_q    <= frame_d;
      running_q  <= running_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_ok && !wb_rst_i) begin
      mem[wr_ptr_q] <= {wr_data_lch, wr_data_rch};
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_spdif_i2s_out.sv
// -----------------------------------------------------------------------------
// tb_spdif_i2s_out
//
// Self-checking bench for spdif_i2s_out (DATA_WIDTH=16, FIFO_AW=2,
// BCLK_DIV=2). A behavioural model tracks the pair FIFO as a queue and, at
// every frame boundary (every 256 wb_clk_i cycles after reset release),
// pushes the frame the DAC should receive into a scoreboard queue. A monitor
// deserialises the I2S stream from LRCK falling edges and pops/compares each
// completed 64-bit frame. BCLK, LRCK, level and sticky flags are also
// checked every cycle against values computed from the cycle count.
// -----------------------------------------------------------------------------
module tb_spdif_i2s_out;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int BD    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = DEPTH / 2;
  localparam int FRAME = 2 * BD * 64;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          wr_en    = 1'b0;
  logic          lock     = 1'b1;
  logic          stat_clr = 1'b0;
  logic [DW-1:0] l_in     = '0;
  logic [DW-1:0] r_in     = '0;

  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic [AW:0]   fifo_level;
  logic          overrun;
  logic          underrun;

  spdif_i2s_out #(
    .DATA_WIDTH (DW),
    .FIFO_AW    (AW),
    .BCLK_DIV   (BD)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wr_en       (wr_en),
    .wr_data_lch (l_in),
    .wr_data_rch (r_in),
    .lock        (lock),
    .stat_clr    (stat_clr),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdata   (i2s_sdata),
    .fifo_level  (fifo_level),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] slots(input logic [2*DW-1:0] p);
    return {p[2*DW-1:DW], {(32-DW){1'b0}}, p[DW-1:0], {(32-DW){1'b0}}};
  endfunction

  // LRCK as seen at shift events k = 1..63 then 0: high for k = 32..63.
  function automatic logic [63:0] lrck_pattern();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[63-i] = (i >= 31 && i <= 62);
    return v;
  endfunction

  // ---------------- reference model ----------------
  int                n        = 0;     // posedges since reset release
  bit                last_rst = 1'b0;  // reset was sampled at the last posedge
  logic [2*DW-1:0]   mq[$];            // model FIFO of {L,R}
  logic [2*DW-1:0]   exp_q[$];         // scoreboard: expected frames
  bit                run_m    = 1'b0;
  bit                ov_m     = 1'b0;
  bit                un_m     = 1'b0;
  logic              prev_wr  = 1'b0;
  bit                m_push, m_mute, m_ov_set, m_un_set;

  always @(posedge clk) begin
    last_rst = rst;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      run_m   = 1'b0;
      ov_m    = 1'b0;
      un_m    = 1'b0;
      prev_wr = 1'b0;
      n       = 0;
    end else begin
      n++;
      m_push   = (wr_en != prev_wr);
      prev_wr  = wr_en;
      m_ov_set = 1'b0;
      m_un_set = 1'b0;
`ifdef SPDIF_I2S_LOCK_MUTE_EN
      m_mute = !lock;
`else
      m_mute = 1'b0;
`endif
      if (n % FRAME == 0) begin
        if (m_mute) begin
          exp_q.push_back('0);
        end else if (run_m) begin
          if (mq.size() > 0) begin
            exp_q.push_back(mq.pop_front());
          end else begin
            exp_q.push_back('0);
            m_un_set = 1'b1;
            run_m    = 1'b0;
          end
        end else begin
          exp_q.push_back('0);
          if (mq.size() >= HALF) run_m = 1'b1;
        end
      end
      if (m_mute) begin
        mq.delete();
        run_m = 1'b0;
      end else if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back({l_in, r_in});
        else m_ov_set = 1'b1;
      end
      ov_m = m_ov_set | (ov_m & !stat_clr);
      un_m = m_un_set | (un_m & !stat_clr);
    end
  end

  // ---------------- monitor ----------------
  bit          armed      = 1'b0;
  logic        prev_bclk  = 1'b0;
  logic        prev_lrck  = 1'b0;
  bit          collecting = 1'b0;
  int          bit_n      = 0;
  int          frames_seen = 0;
  logic [63:0] cap, lr;
  logic [63:0] lr_exp;
  logic [2*DW-1:0] ef;

  initial lr_exp = lrck_pattern();

  always @(negedge clk) begin
    if (last_rst) begin
      armed = 1'b1;
      chk("rst_bclk",  64'(i2s_bclk),   64'd0);
      chk("rst_lrck",  64'(i2s_lrck),   64'd0);
      chk("rst_sdata", 64'(i2s_sdata),  64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ovr",   64'(overrun),    64'd0);
      chk("rst_unr",   64'(underrun),   64'd0);
      collecting = 1'b0;
      bit_n      = 0;
      prev_bclk  = 1'b0;
      prev_lrck  = 1'b0;
    end else if (armed) begin
      chk("bclk",       64'(i2s_bclk),   64'((n / BD) % 2));
      chk("lrck",       64'(i2s_lrck),   64'(((n / (2*BD)) % 64) >= 32));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overrun",    64'(overrun),    64'(ov_m));
      chk("underrun",   64'(underrun),   64'(un_m));
      if (prev_bclk && !i2s_bclk) begin
        if (collecting) begin
          cap = {cap[62:0], i2s_sdata};
          lr  = {lr[62:0], i2s_lrck};
          bit_n++;
          if (bit_n == 64) begin
            collecting = 1'b0;
            frames_seen++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL frame_unexpected: got frame 0x%h, expected none", cap);
            end else begin
              ef = exp_q.pop_front();
              $display("frame %0d: L=0x%h R=0x%h", frames_seen, cap[63:48], cap[31:16]);
              chk("frame_data",   cap, slots(ef));
              chk("lrck_pattern", lr,  lr_exp);
            end
          end
        end
        if (prev_lrck && !i2s_lrck) begin
          collecting = 1'b1;
          bit_n      = 0;
        end
      end
      prev_bclk = i2s_bclk;
      prev_lrck = i2s_lrck;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_n(input int t);
    while (n < t) @(negedge clk);
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    l_in  = l;
    r_in  = r;
    wr_en = ~wr_en;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  int start_n;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Priming with three identical pairs, later underrun and re-prime.
    wait_n(9);  push_pair(16'hA55A, 16'h0F0F);
    wait_n(13); push_pair(16'hA55A, 16'h0F0F);
    wait_n(17); push_pair(16'hA55A, 16'h0F0F);
    wait_n(1299);
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    // Reset in the middle of a frame carrying real data.
    wait_n(2100);
    do_reset(3);

    // Overrun: five pushes in quick succession while not running.
    for (int i = 0; i < 5; i++) begin
      wait_n(4 + 3*i);
      push_pair(DW'($urandom), DW'($urandom));
    end
    wait_n(39);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    // Push on the very cycle of a frame-load pop with the FIFO full.
    wait_n(2*FRAME - 1);
    push_pair(16'h1234, 16'hFEDC);

    // Lock segment (only effective when the mute feature is built in).
    wait_n(1899);
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    wait_n(1950); lock = 1'b0;
    wait_n(2000); push_pair(DW'($urandom), DW'($urandom));
    wait_n(2010); push_pair(DW'($urandom), DW'($urandom));
    wait_n(2250); lock = 1'b1;
    wait_n(2299);
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));

    // Randomised traffic: a busy half then a sparse half.
    start_n = n;
    while (n < start_n + 12000) begin
      stat_clr = ($urandom_range(0, 999) == 0);
      lock     = !($urandom_range(0, 299) == 0);
      if ($urandom_range(0, (n < start_n + 6000) ? 179 : 399) == 0) begin
        l_in  = DW'($urandom);
        r_in  = DW'($urandom);
        wr_en = ~wr_en;
      end
      @(negedge clk);
    end
    stat_clr = 1'b0;
    lock     = 1'b1;
    repeat (4) @(negedge clk);

    chk("frames_seen_min", 64'(frames_seen >= 40), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
